// File: rtl/audiodac_i2s_rx.sv
// audiodac_i2s_rx: I2S receiver feeding the DAC FIFO through a 4-phase rdy/ack handshake.
// Define AUDIODAC_I2S_RX_MONO_MIX_EN to output (left+right)>>>1 instead of a selected channel.
module audiodac_i2s_rx #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             i2s_bclk_i,
   input  logic             i2s_ws_i,
   input  logic             i2s_sd_i,
   input  logic             ch_sel_i,
   output logic [WIDTH-1:0] fifo_indata_o,
   output logic             fifo_indata_rdy_o,
   input  logic             fifo_indata_ack_i,
   output logic             overrun_o,
   input  logic             overrun_clr_i
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

   state_t           state;
   logic [2:0]       bclk_q;
   logic [1:0]       ws_q;
   logic [1:0]       sd_q;
   logic [1:0]       ack_q;
   logic             bit_ev;
   logic             ws;
   logic             sd;
   logic             ack;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] word_nx;
   logic [WIDTH-1:0] left_hold;
   logic [WIDTH-1:0] samp;
   logic [CW-1:0]    bit_cnt;
   logic             ws_prev;
   logic             ws_valid;
   logic             synced;
   logic             ws_chg;
   logic             frame_done;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bclk_q <= '0;
         ws_q   <= '0;
         sd_q   <= '0;
         ack_q  <= '0;
      end else begin
         bclk_q <= {bclk_q[1:0], i2s_bclk_i};
         ws_q   <= {ws_q[0], i2s_ws_i};
         sd_q   <= {sd_q[0], i2s_sd_i};
         ack_q  <= {ack_q[0], fifo_indata_ack_i};
      end
   end

   assign bit_ev = bclk_q[1] & ~bclk_q[2];
   assign ws     = ws_q[1];
   assign sd     = sd_q[1];
   assign ack    = ack_q[1];

   // word_nx is the word including the current bit; bits past WIDTH are dropped
   always_comb begin
      word_nx = word;
      for (int i = 0; i < WIDTH; i++) begin
         if (bit_cnt == CW'(WIDTH - 1 - i)) word_nx[i] = sd;
      end
      ws_chg     = enable_i & bit_ev & ws_valid & (ws != ws_prev);
      frame_done = ws_chg & synced & ws_prev;
   end

   // The first ws change after reset/enable only aligns; the word it closes is partial
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word      <= '0;
         bit_cnt   <= '0;
         ws_prev   <= 1'b0;
         ws_valid  <= 1'b0;
         synced    <= 1'b0;
         left_hold <= '0;
      end else if (!enable_i) begin
         word     <= '0;
         bit_cnt  <= '0;
         ws_prev  <= 1'b0;
         ws_valid <= 1'b0;
         synced   <= 1'b0;
      end else if (bit_ev) begin
         ws_prev  <= ws;
         ws_valid <= 1'b1;
         if (ws_chg) begin
            word    <= '0;
            bit_cnt <= '0;
            synced  <= 1'b1;
            if (synced && !ws_prev) left_hold <= word_nx;
         end else begin
            word <= word_nx;
            if (bit_cnt != CW'(WIDTH)) bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

`ifdef AUDIODAC_I2S_RX_MONO_MIX_EN
   logic [WIDTH:0] sum;
   logic           unused_ch_sel;
   assign unused_ch_sel = ch_sel_i;
   assign sum  = {left_hold[WIDTH-1], left_hold} + {word_nx[WIDTH-1], word_nx};
   assign samp = sum[WIDTH:1];
`else
   assign samp = ch_sel_i ? word_nx : left_hold;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state             <= IDLE;
         fifo_indata_o     <= {1'b1, {(WIDTH-1){1'b0}}};
         fifo_indata_rdy_o <= 1'b0;
         overrun_o         <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (frame_done) begin
                  fifo_indata_o     <= {~samp[WIDTH-1], samp[WIDTH-2:0]};
                  fifo_indata_rdy_o <= 1'b1;
                  state             <= REQ;
               end
            end
            REQ: begin
               if (ack) begin
                  fifo_indata_rdy_o <= 1'b0;
                  state             <= RELEASE;
               end
            end
            RELEASE: begin
               if (!ack) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (frame_done && state != IDLE) overrun_o <= 1'b1;
         else if (overrun_clr_i)          overrun_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audiodac_i2s_rx.sv
// tb_audiodac_i2s_rx: random and directed I2S frames checked against a behavioural model.
// Honours AUDIODAC_I2S_RX_MONO_MIX_EN in the reference model.
module tb_audiodac_i2s_rx;

   logic        clk = 0;
   logic        rst = 1;
   logic        enable = 0;
   logic        bclk = 0;
   logic        ws_in = 0;
   logic        sd_in = 0;
   logic        ch_sel = 0;
   logic [15:0] data;
   logic        rdy;
   logic        ack = 0;
   logic        ovr;
   logic        ovr_clr = 0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   audiodac_i2s_rx #(.WIDTH(16)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .enable_i          (enable),
      .i2s_bclk_i        (bclk),
      .i2s_ws_i          (ws_in),
      .i2s_sd_i          (sd_in),
      .ch_sel_i          (ch_sel),
      .fifo_indata_o     (data),
      .fifo_indata_rdy_o (rdy),
      .fifo_indata_ack_i (ack),
      .overrun_o         (ovr),
      .overrun_clr_i     (ovr_clr)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // MSB-align an n-bit word into 16 bits: pad short, truncate long
   function automatic logic [15:0] align(input logic [31:0] v, input int n);
      logic [31:0] t;
      t = v << (32 - n);
      return t[31:16];
   endfunction

   function automatic logic [15:0] ref_out(input logic [15:0] l,
                                           input logic [15:0] r,
                                           input logic sel);
      int s;
`ifdef AUDIODAC_I2S_RX_MONO_MIX_EN
      s = (int'($signed(l)) + int'($signed(r))) >>> 1;
`else
      s = sel ? int'($signed(r)) : int'($signed(l));
`endif
      return 16'(s) ^ 16'h8000;
   endfunction

   task automatic send_bit(input logic ws, input logic sd, input bit meas);
      @(negedge clk);
      ws_in = ws;
      sd_in = sd;
      bclk  = 0;
      repeat (4) @(negedge clk);
      bclk = 1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (meas && i == 2) check("rdy_early", 32'(rdy), 32'd0);
         if (meas && i == 3) check("rdy_lat", 32'(rdy), 32'd1);
      end
      bclk = 0;
   endtask

   // I2S: the word's LSB is sent with ws already showing the next channel
   task automatic send_word(input logic ch, input logic [31:0] v,
                            input int n, input bit meas);
      for (int i = 0; i < n; i++)
         send_bit((i == n - 1) ? ~ch : ch, v[n-1-i], meas && (i == n - 1));
   endtask

   task automatic lead_in();
      send_word(1'b1, 32'h0, 2, 1'b0);
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                             input int n, input bit meas);
      send_word(1'b0, l, n, 1'b0);
      send_word(1'b1, r, n, meas);
   endtask

   task automatic wait_rdy();
      for (int i = 0; i < 400 && !rdy; i++) @(negedge clk);
      check("rdy_seen", 32'(rdy), 32'd1);
   endtask

   task automatic handshake(input logic [15:0] exp, input int dly);
      wait_rdy();
      check("data", 32'(data), 32'(exp));
      repeat (dly) @(negedge clk);
      ack = 1;
      @(negedge clk);
      check("rdy_hold1", 32'(rdy), 32'd1);
      @(negedge clk);
      check("rdy_hold2", 32'(rdy), 32'd1);
      @(negedge clk);
      check("rdy_fall", 32'(rdy), 32'd0);
      check("data_stable", 32'(data), 32'(exp));
      ack = 0;
      repeat (3) @(negedge clk);
      check("data_release", 32'(data), 32'(exp));
   endtask

   task automatic frame_check(input logic [31:0] l, input logic [31:0] r,
                              input int n, input logic sel, input int dly);
      ch_sel = sel;
      send_frame(l, r, n, 1'b1);
      handshake(ref_out(align(l, n), align(r, n), sel), dly);
   endtask

   initial begin
      logic [15:0] e1;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(data), 32'h8000);
      check("rst_rdy", 32'(rdy), 32'd0);
      check("rst_ovr", 32'(ovr), 32'd0);
      rst = 0;
      enable = 1;
      lead_in();

      frame_check(32'h1234, 32'h0000, 16, 1'b0, 5);
      frame_check(32'h1234, 32'h0000, 16, 1'b1, 5);
      frame_check(32'h7FFF, 32'h7FFF, 16, 1'b0, 2);
      frame_check(32'h8000, 32'h7FFF, 16, 1'b1, 2);
      frame_check(32'hABCD0001, 32'h55550000, 32, 1'b0, 3);
      frame_check(32'h00000012, 32'h00000080, 8, 1'b0, 1);
      frame_check(32'h00000012, 32'h00000080, 8, 1'b1, 1);

      for (int k = 0; k < 12; k++) begin
         int n;
         n = 8 * int'($urandom_range(1, 4));
         frame_check($urandom, $urandom, n, 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 6)));
      end

      // Overrun: second frame arrives while the first is still unacknowledged
      ch_sel = 0;
      e1 = ref_out(16'h1111, 16'h2222, 1'b0);
      send_frame(32'h1111, 32'h2222, 16, 1'b0);
      wait_rdy();
      check("ovr_before", 32'(ovr), 32'd0);
      send_frame(32'h3333, 32'h4444, 16, 1'b0);
      check("ovr_set", 32'(ovr), 32'd1);
      check("ovr_data", 32'(data), 32'(e1));
      handshake(e1, 1);
      check("ovr_sticky", 32'(ovr), 32'd1);
      ovr_clr = 1;
      @(negedge clk);
      ovr_clr = 0;
      check("ovr_clr", 32'(ovr), 32'd0);

      // Disabled: a full frame must not complete
      enable = 0;
      send_frame(32'h5A5A, 32'hA5A5, 16, 1'b0);
      repeat (5) @(negedge clk);
      check("dis_rdy", 32'(rdy), 32'd0);
      enable = 1;
      lead_in();
      frame_check(32'h0F0F, 32'hF0F0, 16, 1'b0, 2);

      // Reset mid-handshake takes effect without a clock edge
      send_frame(32'h6789, 32'h1357, 16, 1'b0);
      wait_rdy();
      rst = 1;
      #1;
      check("rreq_rdy", 32'(rdy), 32'd0);
      check("rreq_data", 32'(data), 32'h8000);
      @(negedge clk);
      rst = 0;
      lead_in();
      frame_check(32'h2468, 32'h8642, 16, 1'b1, 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
